// File: rtl/tc_pad_serdes.sv
// Pad-side serializer/deserializer.
// RX: assembles PAD_W-wide beats into CORE_IN_W-wide words and buffers them in a small FIFO.
// TX: captures a CORE_OUT_W-wide word and emits it as PAD_W-wide beats, LSB beat first.
// The two paths share only the clock and reset.
module tc_pad_serdes #(
  parameter int unsigned PAD_W      = 8,
  parameter int unsigned CORE_IN_W  = 69,
  parameter int unsigned CORE_OUT_W = 64,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  sync_i,
  input  logic                  pad_v_i,
  input  logic [PAD_W-1:0]      pad_data_i,
  output logic                  pad_ready_o,
  output logic                  core_v_o,
  output logic [CORE_IN_W-1:0]  core_data_o,
  input  logic                  core_yumi_i,
  input  logic                  core_v_i,
  input  logic [CORE_OUT_W-1:0] core_data_i,
  output logic                  core_ready_o,
  output logic                  pad_v_o,
  output logic [PAD_W-1:0]      pad_data_o,
  input  logic                  pad_yumi_i
);

  localparam int unsigned BEATS_IN  = (CORE_IN_W + PAD_W - 1) / PAD_W;
  localparam int unsigned BEATS_OUT = (CORE_OUT_W + PAD_W - 1) / PAD_W;
  localparam int unsigned RX_CNT_W  = (BEATS_IN > 1) ? $clog2(BEATS_IN) : 1;
  localparam int unsigned TX_CNT_W  = (BEATS_OUT > 1) ? $clog2(BEATS_OUT) : 1;
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TX_EXT_W  = BEATS_OUT * PAD_W;

  localparam logic [RX_CNT_W-1:0] RX_LAST  = RX_CNT_W'(BEATS_IN - 1);
  localparam logic [TX_CNT_W-1:0] TX_LAST  = TX_CNT_W'(BEATS_OUT - 1);
  localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  // ---------------------------------------------------------------- RX path
  logic [RX_CNT_W-1:0]  rx_cnt_q;
  logic [CORE_IN_W-1:0] asm_q;
  logic [CORE_IN_W-1:0] beat_word;
  logic                 rx_accept;
  logic                 push;
  logic                 pop;

  logic [CORE_IN_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Last beat may only land when the FIFO has room; registered state only.
  assign pad_ready_o = (rx_cnt_q != RX_LAST) | (count_q < CNT_FULL);
  assign rx_accept   = pad_v_i & pad_ready_o & ~sync_i;
  assign push        = rx_accept & (rx_cnt_q == RX_LAST);
  assign pop         = core_yumi_i & (count_q != '0);
  assign core_v_o    = (count_q != '0);
  assign core_data_o = mem_q[rd_ptr_q];

  // Merge the incoming beat into its slot; bits past CORE_IN_W are dropped.
  always_comb begin
    beat_word = asm_q;
    for (int unsigned i = 0; i < CORE_IN_W; i++) begin
      if (rx_cnt_q == RX_CNT_W'(i / PAD_W)) beat_word[i] = pad_data_i[i % PAD_W];
    end
  end

  // Beat counter and partial-word register; sync discards the partial word.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_cnt_q <= '0;
      asm_q    <= '0;
    end else if (sync_i) begin
      rx_cnt_q <= '0;
      asm_q    <= '0;
    end else if (rx_accept) begin
      if (push) begin
        rx_cnt_q <= '0;
        asm_q    <= '0;
      end else begin
        rx_cnt_q <= rx_cnt_q + RX_CNT_W'(1);
        asm_q    <= beat_word;
      end
    end
  end

  // Receive FIFO: circular buffer with occupancy count.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= beat_word;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------- TX path
  logic [0:0]            state_q;
  logic [TX_CNT_W-1:0]   tx_cnt_q;
  logic [CORE_OUT_W-1:0] tx_data_q;
  logic [TX_EXT_W-1:0]   tx_ext;
  logic                  tx_accept;

  assign core_ready_o = (state_q == StIdle);
  assign pad_v_o      = (state_q == StSend);
  assign tx_accept    = core_v_i & core_ready_o;

  // Zero-extend the captured word so the final beat reads 0 above CORE_OUT_W.
  always_comb begin
    tx_ext                   = '0;
    tx_ext[CORE_OUT_W-1:0]   = tx_data_q;
    pad_data_o               = '0;
    if (state_q == StSend) pad_data_o = tx_ext[tx_cnt_q * PAD_W +: PAD_W];
  end

  // TX state, beat index and capture register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      tx_cnt_q  <= '0;
      tx_data_q <= '0;
    end else if (tx_accept) begin
      state_q   <= StSend;
      tx_cnt_q  <= '0;
      tx_data_q <= core_data_i;
    end else if ((state_q == StSend) && pad_yumi_i) begin
      if (tx_cnt_q == TX_LAST) begin
        state_q  <= StIdle;
        tx_cnt_q <= '0;
      end else begin
        tx_cnt_q <= tx_cnt_q + TX_CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/tc_pad_serdes.md
TC_PAD_SERDES -- requirements
Module: tc_pad_serdes

Interface
REQ-001 Parameter PAD_W, default 8: pad-side data width per beat.
REQ-002 Parameter CORE_IN_W, default 69: width of the assembled core-side receive word.
REQ-003 Parameter CORE_OUT_W, default 64: width of the core-side transmit word.
REQ-004 Parameter FIFO_DEPTH, default 2: number of assembled receive words buffered; legal values are FIFO_DEPTH>=1 and CORE_IN_W, CORE_OUT_W >= PAD_W.
REQ-005 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset_i  in  1  asynchronous, active-high reset.
REQ-007 sync_i  in  1  synchronous receive-framing resync.
REQ-008 pad_v_i  in  1  receive beat valid.
REQ-009 pad_data_i  in  PAD_W  receive beat data.
REQ-010 pad_ready_o  out  1  receive beat accepted when pad_v_i&pad_ready_o.
REQ-011 core_v_o  out  1  assembled word valid at FIFO head.
REQ-012 core_data_o  out  CORE_IN_W  FIFO head word.
REQ-013 core_yumi_i  in  1  consumer pops head; legal only while core_v_o=1.
REQ-014 core_v_i  in  1  transmit word valid.
REQ-015 core_data_i  in  CORE_OUT_W  transmit word.
REQ-016 core_ready_o  out  1  transmit word accepted when core_v_i&core_ready_o.
REQ-017 pad_v_o  out  1  transmit beat valid.
REQ-018 pad_data_o  out  PAD_W  transmit beat data.
REQ-019 pad_yumi_i  in  1  pad side consumes current beat; legal only while pad_v_o=1.

Function
REQ-020 BEATS_IN=ceil(CORE_IN_W/PAD_W) and BEATS_OUT=ceil(CORE_OUT_W/PAD_W), fixed at elaboration.
REQ-021 RX beat counter rx_cnt runs 0..BEATS_IN-1; an accepted beat at rx_cnt=k is written to word bits [k*PAD_W +: PAD_W], with bits at or above CORE_IN_W discarded.
REQ-022 The accepted beat at rx_cnt=BEATS_IN-1 pushes the completed word into the FIFO and wraps rx_cnt to 0; core_v_o rises the following cycle (latency 1).
REQ-023 pad_ready_o = (rx_cnt != BEATS_IN-1) | (fifo_count < FIFO_DEPTH), derived from registered state only; it never depends combinationally on core_yumi_i.
REQ-024 Push and pop in the same cycle: fifo_count is unchanged and FIFO order is preserved; pop from an empty FIFO does not occur.
REQ-025 core_v_o = (fifo_count != 0); the FIFO is first-in first-out.
REQ-026 sync_i=1 forces rx_cnt to 0 and discards the partial word and any beat presented that cycle; FIFO contents and the TX path are unaffected.
REQ-027 TX states are IDLE and SEND; core_ready_o = (state==IDLE).
REQ-028 IDLE to SEND: on core_v_i&core_ready_o, capture core_data_i and set tx_cnt=0; pad_v_o rises the following cycle.
REQ-029 In SEND, pad_data_o = captured bits [tx_cnt*PAD_W +: PAD_W], with bits at or above CORE_OUT_W driven 0; pad_data_o holds stable until pad_yumi_i.
REQ-030 pad_yumi_i increments tx_cnt; pad_yumi_i at tx_cnt=BEATS_OUT-1 returns to IDLE, and core_ready_o is 1 the next cycle (one idle cycle between words).
REQ-031 The RX and TX paths are fully independent and operate concurrently.

Reset
REQ-032 reset_i assertion immediately clears rx_cnt, tx_cnt, fifo_count, the FIFO storage, and the TX capture register, and forces TX to IDLE.
REQ-033 Output values under reset: pad_ready_o=1, core_v_o=0, core_data_o=0, core_ready_o=1, pad_v_o=0, pad_data_o=0.
REQ-034 Reset mid-word or mid-transmit drops all partial data; no residual beat or word appears after release.

Verification
REQ-035 Defaults, core_yumi_i=0, 9 beats 0x01..0x09 -> core_v_o=1 one cycle after the 9th beat, core_data_o=69'h09_0807060504030201.
REQ-036 FIFO_DEPTH=2, core_yumi_i=0, 27 beats offered back-to-back -> pad_ready_o=0 at rx_cnt=8 with fifo_count=2; a single core_yumi_i returns pad_ready_o=1 the next cycle, and the third word then completes.
REQ-037 core_data_i=64'h0123456789ABCDEF, pad_yumi_i held at 1 -> pad_data_o = EF,CD,AB,89,67,45,23,01 on consecutive cycles, then core_ready_o=1.
REQ-038 4 beats, then a sync_i pulse, then 9 beats 0x11..0x19 -> exactly one word, containing only 0x11..0x19.
REQ-039 fifo_count=1, last beat accepted in the same cycle as core_yumi_i -> fifo_count stays 1 and the new word appears at the head next cycle.
REQ-040 reset_i pulsed after 3 TX beats -> pad_v_o=0 immediately; after release core_ready_o=1 and no further beats appear.
